// File: rtl/ifu.sv
// ifu: instruction fetch unit. Holds the PC, issues one 32-bit fetch at a time,
//      registers the returned word with its PC and hands it to decode.
// Latency: REQ -> WAIT -> OUT, 3 cycles per instruction best case; out_valid
//      rises one cycle after the memory response.
// Backpressure: out_ready low holds the registered instruction stable in OUT
//      and blocks new fetches. Memory responses are never back-pressured.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   halt                      level, blocks new fetch requests only
//   redirect_valid/_pc        one-cycle PC redirect, kills in-flight work
//   imem_req_valid/_ready     fetch request handshake, imem_addr = pc
//   imem_rsp_valid/_data/_err fetch response (one outstanding at most)
//   out_valid/_ready          handoff to decode with out_inst/out_pc/out_err
//   fetch_cnt                 instructions handed to decode (wraps at 2^64)
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        out_err,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        drop, drop_nxt;
  logic [63:0] pc;
  logic        capture;
  logic        fire;

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
    end
  end

  // Outputs are forced low while rst is high so no request leaks out during
  // a multi-cycle reset.
  always_comb begin
    state_nxt      = state;
    drop_nxt       = drop;
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    capture        = 1'b0;
    fire           = 1'b0;
    if (!rst) begin
      case (state)
        S_REQ: begin
          // Suppressed on redirect so the old PC never handshakes.
          imem_req_valid = !halt && !redirect_valid;
          if (imem_req_valid && imem_req_ready) begin
            state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            if (imem_rsp_valid) begin
              // Response for the killed fetch arrives right now: just drop it.
              state_nxt = S_REQ;
              drop_nxt  = 1'b0;
            end else begin
              // Response still pending: remember to discard it when it lands.
              drop_nxt = 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop) begin
              drop_nxt  = 1'b0;
              state_nxt = S_REQ;
            end else begin
              capture   = 1'b1;
              state_nxt = S_OUT;
            end
          end
        end
        S_OUT: begin
          out_valid = !redirect_valid;
          if (redirect_valid) begin
            state_nxt = S_REQ;
          end else if (out_ready) begin
            fire      = 1'b1;
            state_nxt = S_REQ;
          end
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      out_inst  <= 32'd0;
      out_pc    <= 64'd0;
      out_err   <= 1'b0;
      fetch_cnt <= 64'd0;
    end else begin
      // Redirect wins over the sequential increment; capture cannot coincide
      // with a redirect, but the priority keeps that explicit.
      if (redirect_valid) begin
        pc <= redirect_pc & ~64'h3;
      end else if (capture) begin
        pc <= pc + 64'd4;
      end
      if (capture) begin
        out_inst <= imem_rsp_data;
        out_pc   <= pc;
        out_err  <= imem_rsp_err;
      end
      if (fire) begin
        fetch_cnt <= fetch_cnt + 64'd1;
      end
    end
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the NPC core. It holds the architectural PC and issues one 32-bit fetch at a time to instruction memory over a valid/ready request and response channel. It registers each returned instruction with its PC and hands both to the decode stage (idu) through a valid/ready output. Redirects from execute (branch/jump target) take priority and kill in-flight work; the ebreak-driven `halt` stops new fetches.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC value loaded at reset.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `halt` input 1: level; when high, no new memory request is issued.
- `redirect_valid` input 1: one-cycle pulse; load new PC and flush.
- `redirect_pc` input 64: target; bits [1:0] are forced to 0 on load.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts request.
- `imem_addr` output 64: fetch address (= current PC).
- `imem_rsp_valid` input 1: response valid; memory never back-pressured on response.
- `imem_rsp_data` input 32: instruction word.
- `imem_rsp_err` input 1: access fault for this response.
- `out_valid` output 1: instruction available to idu.
- `out_ready` input 1: idu accepts.
- `out_inst` output 32: instruction.
- `out_pc` output 64: PC of `out_inst`.
- `out_err` output 1: fetch fault flag travelling with instruction.
- `fetch_cnt` output 64: count of instructions handed to idu.

## Operation
- States: REQ, WAIT, OUT; one-hot or encoded.
- REQ: `imem_req_valid = !halt && !redirect_valid`; `imem_addr = pc`. If request handshakes, go to WAIT.
- WAIT: hold request low. On `imem_rsp_valid`:
  - If `drop` is clear, capture `out_inst`, `out_pc <= pc`, and `out_err`. Set `pc <= pc + 4` (64-bit wrap), then go to OUT.
  - If `drop` is set, discard the response, clear `drop`, and go to REQ.
- OUT: `out_valid = !redirect_valid`. On `out_valid && out_ready`, increment `fetch_cnt` (wraps at 2^64) and go to REQ.
- Redirect, applied in any state on the edge it is sampled: `pc <= {redirect_pc[63:2],2'b00}`.
  - REQ: stay in REQ. The request is suppressed that cycle, so there is no stale handshake.
  - WAIT, no response this cycle: set `drop` and stay in WAIT.
  - WAIT, with response this cycle: discard the response and go to REQ. `drop` stays clear.
  - OUT: discard the output and go to REQ. No fire, no count.
- `halt` only gates new requests. An outstanding WAIT completes and the OUT handoff proceeds normally. Redirect while halted still updates `pc`.
- `out_inst`, `out_pc` and `out_err` are stable while `out_valid && !out_ready`.

## Timing
- Reset values: state=REQ, `pc=RESET_PC`, `drop=0`, `out_inst=0`, `out_pc=0`, `out_err=0`, `fetch_cnt=0`. `imem_req_valid=0` during reset; it is first asserted in the cycle after `rst` falls, if `halt=0`.
- Reset mid-operation discards everything; any response arriving later is ignored in REQ.
- `imem_rsp_valid` outside WAIT is ignored.
- Best case (ready and response each one cycle later, `out_ready=1`): REQ, WAIT, OUT gives 3 cycles per instruction. `out_valid` rises 1 cycle after the response.
- Memory latency is unbounded; the WAIT duration has no timeout.
- Outputs `imem_req_valid` and `out_valid` depend combinationally on `halt` and `redirect_valid`. All other outputs are registered.

## Test plan
- Reset then free-run: memory returns 32'h00100093 (addi x1,x0,1) at every address with 1-cycle latency, `out_ready=1` -> `out_pc` sequence 8000_0000, 8000_0004, 8000_0008, one instruction per 3 cycles, `fetch_cnt`=3 after the third fire.
- Back-pressure: `out_ready=0` for 5 cycles in OUT -> `out_valid` held high, data stable, no new `imem_req_valid`. Releasing gives exactly one fire, and `fetch_cnt` increments by 1.
- Redirect during WAIT to 64'h8000_0103, response arrives 3 cycles later -> response discarded, next `imem_addr`=8000_0100, no `out_valid` for the dropped fetch. Repeat with redirect coincident with the response: same result.
- Redirect in OUT with `out_ready=1` the same cycle -> `out_valid`=0, no count, next request at the target.
- `halt`=1 while in WAIT -> the pending instruction is delivered, then `imem_req_valid` stays 0. Deassert `halt` -> request at the next PC (+4).
- `imem_rsp_err`=1 at 8000_0008 -> `out_err`=1 with `out_pc`=8000_0008, and the next fetch proceeds to 8000_000C with `out_err`=0.
